otp_stream_decryptor: RTL and testbench

Receive-side one-time-pad decryptor. It accepts framed 32-bit ciphertext words and a separate stream of pad (key) words, and produces plaintext as `ct_data ^ key_data`, one pad word per ciphertext word. A pad-budget counter guarantees that no pad word is ever consumed twice between reloads. The block sits between the link receiver and the consumer, mirroring the XOR encryptor on the transmit side.

---
 rtl/otp_stream_decryptor_if.sv | 26 ++
 rtl/otp_stream_decryptor.sv | 114 +++++++++++
 tb/tb_otp_stream_decryptor.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/otp_stream_decryptor_if.sv
// Ciphertext, pad and plaintext stream handshakes for the OTP decryptor.
interface otp_stream_decryptor_if;
  logic        ct_valid;
  logic        ct_ready;
  logic [31:0] ct_data;
  logic        ct_last;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] key_data;
  logic        pt_valid;
  logic        pt_ready;
  logic [31:0] pt_data;
  logic        pt_last;

  // Source side: drives ciphertext and pad words, consumes plaintext.
  modport master (
    output ct_valid, ct_data, ct_last, key_valid, key_data, pt_ready,
    input  ct_ready, key_ready, pt_valid, pt_data, pt_last
  );

  // Decryptor side.
  modport slave (
    input  ct_valid, ct_data, ct_last, key_valid, key_data, pt_ready,
    output ct_ready, key_ready, pt_valid, pt_data, pt_last
  );
endinterface

// File: rtl/otp_stream_decryptor.sv
// One-time-pad stream decryptor: plaintext = ciphertext ^ pad word, with a
// pad budget that prevents any pad word from being consumed twice.
module otp_stream_decryptor #(
  parameter int unsigned PAD_WORDS = 1024,
  parameter int unsigned MAX_FRAME = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  otp_stream_decryptor_if.slave  s,
  input  logic                   pad_reload,
  input  logic                   err_clr,
  output logic [15:0]            pad_left,
  output logic                   pad_empty,
  output logic [15:0]            frame_cnt,
  output logic                   err_overlong
);

  localparam logic [15:0] PAD_INIT  = 16'(PAD_WORDS);
  localparam logic [15:0] FRAME_MAX = 16'(MAX_FRAME);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] word_cnt;

  logic slot_free;
  logic go;
  logic at_max;
  logic discard;
  logic fire;
  logic drop_acc;

  // Handshake decode: decrypt transfers need both streams, discards need only ciphertext.
  always_comb begin
    slot_free   = !s.pt_valid || s.pt_ready;
    go          = !pad_reload && !pad_empty && slot_free;
    at_max      = (state == RUN) && (word_cnt == FRAME_MAX);
    discard     = (state == DROP) || at_max;
    s.ct_ready  = discard ? 1'b1 : (go && s.key_valid);
    s.key_ready = discard ? 1'b0 : (go && s.ct_valid);
    fire        = !discard && go && s.ct_valid && s.key_valid;
    drop_acc    = discard && s.ct_valid;
  end

  // Plaintext output register; holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.pt_valid <= 1'b0;
      s.pt_data  <= 32'd0;
      s.pt_last  <= 1'b0;
    end else if (fire) begin
      s.pt_valid <= 1'b1;
      s.pt_data  <= s.ct_data ^ s.key_data;
      s.pt_last  <= s.ct_last;
    end else if (s.pt_ready) begin
      s.pt_valid <= 1'b0;
    end
  end

  // Pad budget; reload never coincides with a consume because go is gated by reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_left  <= PAD_INIT;
      pad_empty <= (PAD_INIT == 16'd0);
    end else if (pad_reload) begin
      pad_left  <= PAD_INIT;
      pad_empty <= (PAD_INIT == 16'd0);
    end else if (fire) begin
      pad_left  <= pad_left - 16'd1;
      pad_empty <= (pad_left == 16'd1);
    end
  end

  // Frame FSM with word counter and completed-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_cnt  <= 16'd0;
      frame_cnt <= 16'd0;
    end else if (fire) begin
      if (s.ct_last) begin
        state     <= IDLE;
        word_cnt  <= 16'd0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        state    <= RUN;
        word_cnt <= word_cnt + 16'd1;
      end
    end else if (drop_acc) begin
      if (s.ct_last) begin
        state    <= IDLE;
        word_cnt <= 16'd0;
      end else begin
        state <= DROP;
      end
    end
  end

  // Sticky overlong flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overlong <= 1'b0;
    end else if (at_max && s.ct_valid) begin
      err_overlong <= 1'b1;
    end else if (err_clr) begin
      err_overlong <= 1'b0;
    end
  end

endmodule

// File: tb/tb_otp_stream_decryptor.sv
// Directed bench for otp_stream_decryptor: dut0 (PAD_WORDS=16, MAX_FRAME=4)
// covers framing, backpressure, starvation, overlong and reset; dut1
// (PAD_WORDS=5, MAX_FRAME=16) covers pad exhaustion and reload.
module tb_otp_stream_decryptor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reload0 = 1'b0, clr0 = 1'b0, reload1 = 1'b0, clr1 = 1'b0;
  logic [15:0] pad_left0, frame_cnt0, pad_left1, frame_cnt1;
  logic pad_empty0, err0, pad_empty1, err1;
  int total = 0;
  int bad = 0;

  otp_stream_decryptor_if i0 ();
  otp_stream_decryptor_if i1 ();

  otp_stream_decryptor #(.PAD_WORDS(16), .MAX_FRAME(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .s(i0.slave), .pad_reload(reload0), .err_clr(clr0),
    .pad_left(pad_left0), .pad_empty(pad_empty0), .frame_cnt(frame_cnt0),
    .err_overlong(err0)
  );

  otp_stream_decryptor #(.PAD_WORDS(5), .MAX_FRAME(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .s(i1.slave), .pad_reload(reload1), .err_clr(clr1),
    .pad_left(pad_left1), .pad_empty(pad_empty1), .frame_cnt(frame_cnt1),
    .err_overlong(err1)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive0(input logic cv, input logic [31:0] cd, input logic cl,
                        input logic kv, input logic [31:0] kd);
    i0.ct_valid = cv; i0.ct_data = cd; i0.ct_last = cl;
    i0.key_valid = kv; i0.key_data = kd;
  endtask

  task automatic drive1(input logic cv, input logic [31:0] cd, input logic cl,
                        input logic kv, input logic [31:0] kd);
    i1.ct_valid = cv; i1.ct_data = cd; i1.ct_last = cl;
    i1.key_valid = kv; i1.key_data = kd;
  endtask

  initial begin
    drive0(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    drive1(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    i0.pt_ready = 1'b1;
    i1.pt_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_pt_valid", 32'(i0.pt_valid), 32'd0);
    chk("rst_pt_data", i0.pt_data, 32'd0);
    chk("rst_pt_last", 32'(i0.pt_last), 32'd0);
    chk("rst_pad_left", 32'(pad_left0), 32'd16);
    chk("rst_pad_empty", 32'(pad_empty0), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic frame
    drive0(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'hFFFFFFFF);
    #1;
    chk("basic_ct_ready", 32'(i0.ct_ready), 32'd1);
    chk("basic_key_ready", 32'(i0.key_ready), 32'd1);
    tick();
    chk("basic_pt0_valid", 32'(i0.pt_valid), 32'd1);
    chk("basic_pt0", i0.pt_data, 32'h21524110);
    chk("basic_pt0_last", 32'(i0.pt_last), 32'd0);
    drive0(1'b1, 32'h12345678, 1'b0, 1'b1, 32'h12345678);
    tick();
    chk("basic_pt1", i0.pt_data, 32'h00000000);
    chk("basic_pt1_valid", 32'(i0.pt_valid), 32'd1);
    drive0(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0F0F0F0F);
    tick();
    chk("basic_pt2", i0.pt_data, 32'hF0F0F0F0);
    chk("basic_pt2_last", 32'(i0.pt_last), 32'd1);
    chk("basic_frame_cnt", 32'(frame_cnt0), 32'd1);
    chk("basic_pad_left", 32'(pad_left0), 32'd13);
    drive0(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    chk("basic_idle_valid", 32'(i0.pt_valid), 32'd0);

    // Backpressure
    drive0(1'b1, 32'h11111111, 1'b0, 1'b1, 32'h22222222);
    tick();
    chk("bp_pt0", i0.pt_data, 32'h33333333);
    chk("bp_pad0", 32'(pad_left0), 32'd12);
    drive0(1'b1, 32'hAAAA0000, 1'b0, 1'b1, 32'h0000AAAA);
    i0.pt_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_ct_ready", 32'(i0.ct_ready), 32'd0);
      chk("bp_key_ready", 32'(i0.key_ready), 32'd0);
      tick();
      chk("bp_hold_data", i0.pt_data, 32'h33333333);
      chk("bp_hold_valid", 32'(i0.pt_valid), 32'd1);
      chk("bp_hold_pad", 32'(pad_left0), 32'd12);
    end
    i0.pt_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(i0.ct_ready), 32'd1);
    tick();
    chk("bp_pt1", i0.pt_data, 32'hAAAAAAAA);
    chk("bp_pad1", 32'(pad_left0), 32'd11);
    drive0(1'b1, 32'h0F0F0F0F, 1'b1, 1'b1, 32'hF0F0F0F0);
    tick();
    chk("bp_pt2", i0.pt_data, 32'hFFFFFFFF);
    chk("bp_pt2_last", 32'(i0.pt_last), 32'd1);
    chk("bp_pad2", 32'(pad_left0), 32'd10);
    chk("bp_frame_cnt", 32'(frame_cnt0), 32'd2);
    drive0(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();

    // Key starvation
    drive0(1'b1, 32'h01020304, 1'b0, 1'b0, 32'h0BADF00D);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("ks_ct_ready", 32'(i0.ct_ready), 32'd0);
      tick();
      chk("ks_no_out", 32'(i0.pt_valid), 32'd0);
      chk("ks_pad", 32'(pad_left0), 32'd10);
    end
    drive0(1'b1, 32'h01020304, 1'b0, 1'b1, 32'h10203040);
    tick();
    chk("ks_pt0", i0.pt_data, 32'h11223344);
    drive0(1'b1, 32'h80000001, 1'b1, 1'b1, 32'h00000001);
    tick();
    chk("ks_pt1", i0.pt_data, 32'h80000000);
    chk("ks_pt1_last", 32'(i0.pt_last), 32'd1);
    chk("ks_pad", 32'(pad_left0), 32'd8);
    chk("ks_frame_cnt", 32'(frame_cnt0), 32'd3);

    // Overlong frame: 7 words against MAX_FRAME=4
    for (int w = 0; w < 4; w++) begin
      drive0(1'b1, 32'h100 + 32'(w), 1'b0, 1'b1, 32'h0F0);
      tick();
      chk("ol_pt", i0.pt_data, 32'h1F0 + 32'(w));
      chk("ol_pt_last", 32'(i0.pt_last), 32'd0);
    end
    for (int w = 4; w < 7; w++) begin
      drive0(1'b1, 32'h100 + 32'(w), (w == 6), 1'b1, 32'h0F0);
      #1;
      chk("ol_drop_ct_ready", 32'(i0.ct_ready), 32'd1);
      chk("ol_drop_key_ready", 32'(i0.key_ready), 32'd0);
      tick();
      chk("ol_drop_no_out", 32'(i0.pt_valid), 32'd0);
    end
    drive0(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("ol_err", 32'(err0), 32'd1);
    chk("ol_frame_cnt", 32'(frame_cnt0), 32'd3);
    chk("ol_pad", 32'(pad_left0), 32'd4);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("ol_err_clr", 32'(err0), 32'd0);

    // Reset mid-frame
    drive0(1'b1, 32'h5, 1'b0, 1'b1, 32'h6);
    tick();
    tick();
    chk("rmf_pad_before", 32'(pad_left0), 32'd2);
    drive0(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rmf_pt_valid", 32'(i0.pt_valid), 32'd0);
    chk("rmf_pt_data", i0.pt_data, 32'd0);
    chk("rmf_pad_left", 32'(pad_left0), 32'd16);
    chk("rmf_frame_cnt", 32'(frame_cnt0), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    drive0(1'b1, 32'hCAFEBABE, 1'b1, 1'b1, 32'hFFFFFFFF);
    tick();
    chk("rmf_pt", i0.pt_data, 32'h35014541);
    chk("rmf_pt_last", 32'(i0.pt_last), 32'd1);
    chk("rmf_frame_cnt_after", 32'(frame_cnt0), 32'd1);
    chk("rmf_pad_after", 32'(pad_left0), 32'd15);
    drive0(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    // Pad exhaustion on dut1: 8-word frame with a 5-word pad
    for (int w = 0; w < 5; w++) begin
      drive1(1'b1, 32'hA0 + 32'(w), 1'b0, 1'b1, 32'h50000000);
      tick();
      chk("pe_pt", i1.pt_data, 32'h500000A0 + 32'(w));
    end
    chk("pe_pad_left", 32'(pad_left1), 32'd0);
    chk("pe_pad_empty", 32'(pad_empty1), 32'd1);
    drive1(1'b1, 32'hA5, 1'b0, 1'b1, 32'h50000000);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("pe_stall_ct_ready", 32'(i1.ct_ready), 32'd0);
      chk("pe_stall_key_ready", 32'(i1.key_ready), 32'd0);
      tick();
      chk("pe_stall_no_out", 32'(i1.pt_valid), 32'd0);
    end
    reload1 = 1'b1;
    #1;
    chk("pe_reload_ct_ready", 32'(i1.ct_ready), 32'd0);
    chk("pe_reload_key_ready", 32'(i1.key_ready), 32'd0);
    tick();
    reload1 = 1'b0;
    chk("pe_reload_pad", 32'(pad_left1), 32'd5);
    chk("pe_reload_empty", 32'(pad_empty1), 32'd0);
    chk("pe_reload_no_out", 32'(i1.pt_valid), 32'd0);
    for (int w = 5; w < 8; w++) begin
      drive1(1'b1, 32'hA0 + 32'(w), (w == 7), 1'b1, 32'h50000000);
      tick();
      chk("pe_tail_pt", i1.pt_data, 32'h500000A0 + 32'(w));
      chk("pe_tail_last", 32'(i1.pt_last), 32'(w == 7));
    end
    drive1(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("pe_frame_cnt", 32'(frame_cnt1), 32'd1);
    chk("pe_pad_final", 32'(pad_left1), 32'd2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
